// File: rtl/keypad_bcd_entry.sv
// 4x4 keypad scanner with debounce, feeding a 4-digit BCD entry register.
// One event per debounced press; digits shift in at the low nibble.
module keypad_bcd_entry #(
   parameter int SCAN_DIV    = 50_000,
   parameter int DEBOUNCE_MS = 20
) (
   input  logic        clk_50M,
   input  logic        rst_n,
   input  logic [3:0]  row_in,
   output logic [3:0]  col_out,
   output logic [3:0]  key_code,
   output logic        key_valid,
   output logic [15:0] disp_bcd
);

   localparam int DW = $clog2(SCAN_DIV);
   localparam int CW = $clog2(DEBOUNCE_MS + 1);

   typedef enum logic [1:0] {
      SCAN,
      DEBOUNCE,
      PRESS,
      RELEASE
   } state_t;

   state_t state_q, state_d;
   logic [3:0]    row_m_q, row_s_q;
   logic [DW-1:0] div_q, div_d;
   logic [3:0]    col_q, col_d;
   logic [3:0]    cand_q, cand_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic [3:0]    code_q, code_d;
   logic          valid_q, valid_d;
   logic [15:0]   disp_q, disp_d;
   logic          tick;
   logic          done;

   function automatic logic [1:0] row_idx(input logic [3:0] r);
      if (!r[0])      return 2'd0;
      else if (!r[1]) return 2'd1;
      else if (!r[2]) return 2'd2;
      else            return 2'd3;
   endfunction

   function automatic logic [1:0] col_idx(input logic [3:0] c);
      case (c)
         4'b1110: return 2'd0;
         4'b1101: return 2'd1;
         4'b1011: return 2'd2;
         default: return 2'd3;
      endcase
   endfunction

   function automatic logic [3:0] key_map(input logic [1:0] r,
                                          input logic [1:0] c);
      case ({r, c})
         4'h0:    return 4'h1;
         4'h1:    return 4'h2;
         4'h2:    return 4'h3;
         4'h3:    return 4'hA;
         4'h4:    return 4'h4;
         4'h5:    return 4'h5;
         4'h6:    return 4'h6;
         4'h7:    return 4'hB;
         4'h8:    return 4'h7;
         4'h9:    return 4'h8;
         4'hA:    return 4'h9;
         4'hB:    return 4'hC;
         4'hC:    return 4'hE;
         4'hD:    return 4'h0;
         4'hE:    return 4'hF;
         default: return 4'hD;
      endcase
   endfunction

   function automatic logic [15:0] edit(input logic [3:0]  code,
                                        input logic [15:0] d);
      if (code <= 4'd9)      return {d[11:0], code};
      else if (code == 4'hA) return 16'h0000;
      else if (code == 4'hB) return {4'h0, d[15:4]};
      else                   return d;
   endfunction

   assign tick    = (div_q == DW'(SCAN_DIV - 1));
   assign cnt_inc = cnt_q + CW'(1);
   assign done    = (cnt_inc == CW'(DEBOUNCE_MS));
   assign div_d   = tick ? '0 : div_q + DW'(1);

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      cand_d  = cand_q;
      cnt_d   = cnt_q;
      code_d  = code_q;
      valid_d = 1'b0;
      disp_d  = disp_q;
      case (state_q)
         SCAN: begin
            if (tick) begin
               if (row_s_q == 4'hF) begin
                  col_d = {col_q[2:0], col_q[3]};
               end else begin
                  cand_d  = row_s_q;
                  cnt_d   = CW'(1);
                  state_d = DEBOUNCE;
               end
            end
         end
         DEBOUNCE: begin
            if (tick) begin
               if (row_s_q == cand_q) begin
                  cnt_d = cnt_inc;
                  // key_valid is registered, so it is raised on the way into PRESS
                  if (done) begin
                     cnt_d   = '0;
                     valid_d = 1'b1;
                     code_d  = key_map(row_idx(cand_q), col_idx(col_q));
                     state_d = PRESS;
                  end
               end else begin
                  cnt_d   = '0;
                  state_d = SCAN;
               end
            end
         end
         PRESS: begin
            disp_d  = edit(code_q, disp_q);
            cnt_d   = '0;
            state_d = RELEASE;
         end
         RELEASE: begin
            if (tick) begin
               if (row_s_q != 4'hF) begin
                  cnt_d = '0;
               end else if (done) begin
                  cnt_d   = '0;
                  state_d = SCAN;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
         end
         default: state_d = SCAN;
      endcase
   end

   always_ff @(posedge clk_50M or negedge rst_n) begin
      if (!rst_n) begin
         row_m_q <= 4'hF;
         row_s_q <= 4'hF;
         div_q   <= '0;
         state_q <= SCAN;
         col_q   <= 4'b1110;
         cand_q  <= 4'hF;
         cnt_q   <= '0;
         code_q  <= 4'h0;
         valid_q <= 1'b0;
         disp_q  <= 16'h0000;
      end else begin
         row_m_q <= row_in;
         row_s_q <= row_m_q;
         div_q   <= div_d;
         state_q <= state_d;
         col_q   <= col_d;
         cand_q  <= cand_d;
         cnt_q   <= cnt_d;
         code_q  <= code_d;
         valid_q <= valid_d;
         disp_q  <= disp_d;
      end
   end

   assign col_out   = col_q;
   assign key_code  = code_q;
   assign key_valid = valid_q;
   assign disp_bcd  = disp_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed bench for keypad_bcd_entry with a switch-matrix keypad model
// and a scoreboard of expected key events.
module tb_keypad_bcd_entry;

   logic        clk_50M = 1'b0;
   logic        rst_n;
   logic [3:0]  row_in;
   logic [3:0]  col_out;
   logic [3:0]  key_code;
   logic        key_valid;
   logic [15:0] disp_bcd;

   logic       key_on;
   logic [1:0] key_r, key_c;

   typedef struct {
      logic [3:0]  code;
      logic [15:0] disp;
   } exp_t;

   exp_t sb[$];
   int errors = 0;
   int checks = 0;
   logic pend = 1'b0;
   logic [15:0] pend_disp;

   always #5 clk_50M = ~clk_50M;

   keypad_bcd_entry #(
      .SCAN_DIV   (10),
      .DEBOUNCE_MS(3)
   ) dut (
      .clk_50M  (clk_50M),
      .rst_n    (rst_n),
      .row_in   (row_in),
      .col_out  (col_out),
      .key_code (key_code),
      .key_valid(key_valid),
      .disp_bcd (disp_bcd)
   );

   always_comb begin
      row_in = 4'hF;
      if (key_on && !col_out[key_c]) row_in[key_r] = 1'b0;
   end

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   always @(negedge clk_50M) begin
      if (!rst_n) begin
         pend = 1'b0;
      end else begin
         if (pend) begin
            check("disp_after_event", disp_bcd, pend_disp);
            pend = 1'b0;
         end
         if (key_valid) begin
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_event: got code %h want none", key_code);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("key_code", {12'h0, key_code}, {12'h0, e.code});
               pend      = 1'b1;
               pend_disp = e.disp;
            end
         end
      end
   end

   task automatic clk_n(input int n);
      repeat (n) @(negedge clk_50M);
   endtask

   task automatic press(input logic [1:0] r, input logic [1:0] c,
                        input logic [3:0] code, input logic [15:0] disp);
      exp_t e;
      e.code = code;
      e.disp = disp;
      sb.push_back(e);
      key_r  = r;
      key_c  = c;
      key_on = 1'b1;
      clk_n(100);
      key_on = 1'b0;
      check("event_consumed", 16'(sb.size()), 16'd0);
      clk_n(60);
   endtask

   task automatic check_reset(input string tag);
      check({tag, "_col"}, {12'h0, col_out}, 16'h000E);
      check({tag, "_code"}, {12'h0, key_code}, 16'h0000);
      check({tag, "_valid"}, {15'h0, key_valid}, 16'h0000);
      check({tag, "_disp"}, disp_bcd, 16'h0000);
   endtask

   initial begin
      logic [3:0] col_exp;
      logic [3:0] col_a;
      exp_t e;
      rst_n  = 1'b0;
      key_on = 1'b0;
      key_r  = 2'd0;
      key_c  = 2'd0;
      clk_n(3);
      check_reset("reset");
      rst_n = 1'b1;

      // idle scan: one rotation per 10 clk
      clk_n(5);
      col_exp = 4'b1110;
      check("scan0", {12'h0, col_out}, {12'h0, col_exp});
      for (int i = 1; i <= 4; i++) begin
         clk_n(10);
         col_exp = {col_exp[2:0], col_exp[3]};
         check("scan_rot", {12'h0, col_out}, {12'h0, col_exp});
      end

      press(2'd0, 2'd1, 4'h2, 16'h0002);
      press(2'd1, 2'd0, 4'h4, 16'h0024);
      press(2'd3, 2'd1, 4'h0, 16'h0240);

      press(2'd0, 2'd0, 4'h1, 16'h2401);
      press(2'd0, 2'd1, 4'h2, 16'h4012);
      press(2'd0, 2'd2, 4'h3, 16'h0123);
      press(2'd1, 2'd1, 4'h5, 16'h1235);
      press(2'd1, 2'd2, 4'h6, 16'h2356);
      press(2'd1, 2'd3, 4'hB, 16'h0235);
      press(2'd0, 2'd3, 4'hA, 16'h0000);

      // bounce on '1'
      e.code = 4'h1;
      e.disp = 16'h0001;
      sb.push_back(e);
      key_r  = 2'd0;
      key_c  = 2'd0;
      key_on = 1'b1;
      clk_n(15);
      key_on = 1'b0;
      clk_n(10);
      key_on = 1'b1;
      clk_n(100);
      key_on = 1'b0;
      check("bounce_one_event", 16'(sb.size()), 16'd0);
      clk_n(60);

      // long hold on '5', then chattering release
      e.code = 4'h5;
      e.disp = 16'h0015;
      sb.push_back(e);
      key_r  = 2'd1;
      key_c  = 2'd1;
      key_on = 1'b1;
      clk_n(1000);
      key_on = 1'b0;
      clk_n(15);
      key_on = 1'b1;
      clk_n(10);
      key_on = 1'b0;
      clk_n(80);
      check("hold_one_event", 16'(sb.size()), 16'd0);
      col_a = col_out;
      clk_n(10);
      check("scan_resumed", {12'h0, col_out},
            {12'h0, col_a[2:0], col_a[3]});

      // reset in the middle of debounce
      rst_n = 1'b0;
      clk_n(1);
      key_r  = 2'd0;
      key_c  = 2'd0;
      key_on = 1'b1;
      rst_n  = 1'b1;
      clk_n(15);
      rst_n = 1'b0;
      #1;
      check_reset("rst_debounce");
      key_on = 1'b0;
      clk_n(3);
      rst_n = 1'b1;
      clk_n(100);
      check("no_event_after_rst", 16'(sb.size()), 16'd0);

      // reset during release
      e.code = 4'h7;
      e.disp = 16'h0007;
      sb.push_back(e);
      key_r  = 2'd2;
      key_c  = 2'd0;
      key_on = 1'b1;
      clk_n(100);
      key_on = 1'b0;
      check("event_7", 16'(sb.size()), 16'd0);
      clk_n(5);
      rst_n = 1'b0;
      #1;
      check_reset("rst_release");
      clk_n(3);
      rst_n = 1'b1;
      clk_n(20);

      press(2'd2, 2'd2, 4'h9, 16'h0009);
      press(2'd3, 2'd0, 4'hE, 16'h0009);

      check("final_sb_empty", 16'(sb.size()), 16'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
